// File: rtl/rx_comma_aligner.sv
// rx_comma_aligner: serial-to-10b symbol aligner ahead of the 8b/10b decoder.
// Hunts for K28.5 in either disparity, locks after LOCK_COUNT phase-consistent
// commas, then emits framed symbols with a one-cycle valid strobe.
//
// Ports:
//   clkRx     in   receive clock, one serial bit per cycle
//   rst       in   synchronous active-high reset
//   enb       in   bit enable; 0 freezes all state (valid is forced low)
//   serialIn  in   recovered serial bit, bit 'a' of a symbol arrives first
//   dataOut10 out  framed symbol, MSB = 'a'
//   valid     out  one-cycle strobe, dataOut10 is new
//   isComma   out  qualifies valid: symbol is COMMA_N or COMMA_P
//   aligned   out  high while locked
module rx_comma_aligner #(
    parameter logic [9:0]  COMMA_N    = 10'b0011111010,
    parameter logic [9:0]  COMMA_P    = 10'b1100000101,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned LOSS_COUNT = 2
) (
    input  logic       clkRx,
    input  logic       rst,
    input  logic       enb,
    input  logic       serialIn,
    output logic [9:0] dataOut10,
    output logic       valid,
    output logic       isComma,
    output logic       aligned
);

    localparam logic [3:0] LOCK_N = LOCK_COUNT[3:0];
    localparam logic [3:0] LOSS_N = LOSS_COUNT[3:0];

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_t;

    state_t     state_q;
    logic [9:0] sr_q;
    logic [3:0] ph_q;
    logic [3:0] cnt_q;
    logic [3:0] err_q;
    logic [9:0] data_q;
    logic       valid_q;
    logic       comma_q;
    logic       aligned_q;

    logic       match;
    logic       boundary;
    logic [3:0] ph_d;
    logic [3:0] cnt_d;
    logic [3:0] err_d;

    always_comb begin
        match    = (sr_q == COMMA_N) || (sr_q == COMMA_P);
        boundary = (ph_q == 4'd0);
        ph_d     = (ph_q == 4'd9) ? 4'd0 : ph_q + 4'd1;
        cnt_d    = cnt_q + 4'd1;
        err_d    = err_q + 4'd1;
    end

    always_ff @(posedge clkRx) begin
        if (rst) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            ph_q      <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            comma_q   <= 1'b0;
            aligned_q <= 1'b0;
        end else if (enb) begin
            sr_q    <= {sr_q[8:0], serialIn};
            ph_q    <= ph_d;
            valid_q <= 1'b0;
            unique case (state_q)
                HUNT: begin
                    // Realign: this cycle acts as the boundary, so the
                    // next symbol completes 10 enabled cycles from now.
                    if (match) begin
                        ph_q    <= 4'd1;
                        cnt_q   <= 4'd1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (match) begin
                        if (!boundary) begin
                            ph_q  <= 4'd1;
                            cnt_q <= 4'd1;
                        end else begin
                            cnt_q <= cnt_d;
                            if (cnt_d == LOCK_N) begin
                                state_q   <= LOCKED;
                                aligned_q <= 1'b1;
                                err_q     <= '0;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        data_q  <= sr_q;
                        comma_q <= match;
                        valid_q <= 1'b1;
                    end
                    // A misaligned comma never moves the phase; only a
                    // run of them drops lock and restarts the hunt.
                    if (match) begin
                        if (boundary) begin
                            err_q <= '0;
                        end else if (err_d == LOSS_N) begin
                            state_q   <= HUNT;
                            aligned_q <= 1'b0;
                            cnt_q     <= '0;
                            err_q     <= '0;
                        end else begin
                            err_q <= err_d;
                        end
                    end
                end
                default: begin
                    state_q <= HUNT;
                end
            endcase
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign dataOut10 = data_q;
    assign valid     = valid_q;
    assign isComma   = comma_q;
    assign aligned   = aligned_q;

endmodule

// File: tb/tb_rx_comma_aligner.sv
// tb_rx_comma_aligner: directed stimulus for rx_comma_aligner.
// Expected symbols are queued as sent and matched against valid strobes.
module tb_rx_comma_aligner;

    localparam logic [9:0] CN = 10'b0011111010;
    localparam logic [9:0] CP = 10'b1100000101;

    logic       clkRx = 1'b0;
    logic       rst;
    logic       enb;
    logic       serialIn;
    logic [9:0] dataOut10;
    logic       valid;
    logic       isComma;
    logic       aligned;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    typedef struct packed {
        logic [9:0]  d;
        logic        c;
        logic [31:0] t;
    } exp_t;

    exp_t sb[$];

    rx_comma_aligner dut (
        .clkRx    (clkRx),
        .rst      (rst),
        .enb      (enb),
        .serialIn (serialIn),
        .dataOut10(dataOut10),
        .valid    (valid),
        .isComma  (isComma),
        .aligned  (aligned)
    );

    always #5 clkRx = ~clkRx;

    always @(posedge clkRx) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_bit(input logic b);
        serialIn = b;
        @(posedge clkRx);
        #1;
    endtask

    task automatic send_sym(input logic [9:0] v, input bit ex);
        for (int i = 9; i >= 0; i--) send_bit(v[i]);
        if (ex) sb.push_back('{d: v, c: (v == CN || v == CP), t: cyc + 1});
    endtask

    // Every cycle: valid must be high exactly when the queue head is due.
    task automatic monitor();
        exp_t e;
        logic ev;
        forever begin
            @(negedge clkRx);
            ev = (sb.size() > 0) && (sb[0].t == cyc);
            check("valid", {31'b0, valid}, {31'b0, ev});
            if (ev) begin
                e = sb.pop_front();
                check("data", {22'b0, dataOut10}, {22'b0, e.d});
                check("isComma", {31'b0, isComma}, {31'b0, e.c});
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_data"}, {22'b0, dataOut10}, 32'd0);
        check({tag, "_valid"}, {31'b0, valid}, 32'd0);
        check({tag, "_isComma"}, {31'b0, isComma}, 32'd0);
        check({tag, "_aligned"}, {31'b0, aligned}, 32'd0);
    endtask

    // 7 junk bits, N, P, N, then data 2B5; lock 20 cycles after the
    // first comma is detected, first output one symbol later.
    task automatic run_lock();
        logic [9:0] d;
        d = 10'h2B5;
        for (int i = 0; i < 7; i++) send_bit(logic'(i % 2 == 0));
        send_sym(CN, 1'b0);
        check("lk_after_c1", {31'b0, aligned}, 32'd0);
        send_sym(CP, 1'b0);
        check("lk_after_c2", {31'b0, aligned}, 32'd0);
        send_sym(CN, 1'b0);
        check("lk_before_rise", {31'b0, aligned}, 32'd0);
        send_bit(d[9]);
        check("lk_rise", {31'b0, aligned}, 32'd1);
        for (int i = 8; i >= 0; i--) send_bit(d[i]);
        sb.push_back('{d: d, c: 1'b0, t: cyc + 1});
    endtask

    initial begin
        logic [9:0]  d;
        logic [29:0] s;

        rst      = 1'b1;
        enb      = 1'b1;
        serialIn = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) begin
            serialIn = 1'($urandom);
            @(posedge clkRx);
            #1;
        end
        chk_zero("rst");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0);
            check("zeros_aligned", {31'b0, aligned}, 32'd0);
        end

        run_lock();
        send_sym(10'h2AA, 1'b1);
        send_sym(CN, 1'b1);

        // One misaligned comma, then an aligned one: lock holds.
        s = {3'b101, CN, 7'b0101010, 10'h000};
        send_sym(s[29:20], 1'b1);
        send_sym(s[19:10], 1'b1);
        send_sym(CN, 1'b1);
        check("loss_hold", {31'b0, aligned}, 32'd1);

        // Two misaligned commas back to back: lock drops on the second.
        s = {3'b101, CN, CP, 7'b0101010};
        send_sym(s[29:20], 1'b1);
        send_sym(s[19:10], 1'b1);
        for (int i = 9; i >= 7; i--) send_bit(s[i]);
        check("loss_pre", {31'b0, aligned}, 32'd1);
        send_bit(s[6]);
        check("loss_fall", {31'b0, aligned}, 32'd0);
        for (int i = 5; i >= 0; i--) send_bit(s[i]);

        // CHECK realign: count restarts at the shifted comma.
        send_sym(CN, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_sym(CP, 1'b0);
        send_sym(CN, 1'b0);
        check("realign_c2", {31'b0, aligned}, 32'd0);
        send_sym(CP, 1'b0);
        check("realign_c3", {31'b0, aligned}, 32'd0);
        send_sym(10'h2AA, 1'b1);
        check("realign_lock", {31'b0, aligned}, 32'd1);

        // Enable gap mid-symbol: outputs shift by exactly the gap.
        send_sym(10'h155, 1'b1);
        d = 10'h2B5;
        for (int i = 9; i >= 6; i--) send_bit(d[i]);
        enb = 1'b0;
        repeat (5) begin
            @(posedge clkRx);
            #1;
            check("gap_valid", {31'b0, valid}, 32'd0);
            check("gap_hold", {22'b0, dataOut10}, 32'h155);
        end
        enb = 1'b1;
        for (int i = 5; i >= 0; i--) send_bit(d[i]);
        sb.push_back('{d: d, c: 1'b0, t: cyc + 1});
        send_sym(10'h2AA, 1'b1);
        check("gap_aligned", {31'b0, aligned}, 32'd1);

        // Reset while locked, mid-symbol, then lock again.
        for (int i = 0; i < 4; i++) send_bit(logic'(i % 2 == 0));
        rst      = 1'b1;
        serialIn = 1'b1;
        @(posedge clkRx);
        #1;
        chk_zero("rst_locked");
        rst = 1'b0;
        run_lock();
        send_sym(10'h2AA, 1'b1);
        repeat (5) send_bit(1'b0);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
